// File: rtl/km_pkg.sv
// Shared widths, FSM encoding and lane pack/unpack helpers for the k-means centroid update.
package km_pkg;

    localparam int CENTROID_NUM     = 8;
    localparam int CORDINATE_WIDTH  = 13;
    localparam int NUM_CORDS        = 7;
    localparam int DATA_WIDTH       = NUM_CORDS * CORDINATE_WIDTH;
    localparam int ACCUM_CORD_WIDTH = 22;
    localparam int ACCUM_WIDTH      = NUM_CORDS * ACCUM_CORD_WIDTH;
    localparam int COUNT_WIDTH      = 10;
    localparam int IDX_WIDTH        = $clog2(CENTROID_NUM);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LOAD = 3'd2,
        DIV  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_e;

    typedef logic [CORDINATE_WIDTH-1:0]  cord_t;
    typedef logic [ACCUM_CORD_WIDTH-1:0] accum_cord_t;

    function automatic accum_cord_t get_sum_lane(input logic [ACCUM_WIDTH-1:0] sums, input int k);
        return sums[k*ACCUM_CORD_WIDTH +: ACCUM_CORD_WIDTH];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] set_cord_lane(input logic [DATA_WIDTH-1:0] point,
                                                            input int k, input cord_t cord);
        logic [DATA_WIDTH-1:0] res;
        res = point;
        res[k*CORDINATE_WIDTH +: CORDINATE_WIDTH] = cord;
        return res;
    endfunction

    // Quotients wider than a coordinate clamp to the largest coordinate.
    function automatic cord_t saturate(input accum_cord_t q);
        return (|q[ACCUM_CORD_WIDTH-1:CORDINATE_WIDTH]) ? {CORDINATE_WIDTH{1'b1}}
                                                          : q[CORDINATE_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/centroid_update_serial_divider.sv
// Restoring serial divider: the load cycle computes the first quotient bit, 21 more follow,
// so the quotient is final 22 cycles after load with q_valid pulsing for one cycle.
module serial_divider
    import km_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [ACCUM_CORD_WIDTH-1:0] dividend,
    input  logic [COUNT_WIDTH-1:0]      divisor,
    output logic                        busy,
    output logic                        q_valid,
    output logic [ACCUM_CORD_WIDTH-1:0] quotient
);

    localparam logic [4:0] STEPS_AFTER_LOAD = 5'd21;

    logic [COUNT_WIDTH-1:0]      rem_q, rem_d, dsr_q, dsr_d;
    logic [ACCUM_CORD_WIDTH-1:0] quo_q, quo_d;
    logic [4:0]                  cnt_q, cnt_d;
    logic                        busy_q, busy_d, valid_q, valid_d;

    logic [COUNT_WIDTH-1:0]      rem_in_s, dsr_in_s, diff_s, rem_step_s;
    logic [ACCUM_CORD_WIDTH-1:0] quo_in_s, quo_step_s;
    logic [COUNT_WIDTH:0]        trial_s;
    logic                        borrow_s;

    // One restoring step: shift in the next dividend bit and subtract when it fits.
    always_comb begin
        rem_in_s = load ? {COUNT_WIDTH{1'b0}} : rem_q;
        quo_in_s = load ? dividend : quo_q;
        dsr_in_s = load ? divisor : dsr_q;
        trial_s  = {rem_in_s, quo_in_s[ACCUM_CORD_WIDTH-1]};
        {borrow_s, diff_s} = trial_s - {1'b0, dsr_in_s};
        if (borrow_s) begin
            rem_step_s = trial_s[COUNT_WIDTH-1:0];
            quo_step_s = {quo_in_s[ACCUM_CORD_WIDTH-2:0], 1'b0};
        end else begin
            rem_step_s = diff_s;
            quo_step_s = {quo_in_s[ACCUM_CORD_WIDTH-2:0], 1'b1};
        end
    end

    // Sequencing of the 22 steps.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        if (load) begin
            rem_d  = rem_step_s;
            quo_d  = quo_step_s;
            dsr_d  = divisor;
            cnt_d  = STEPS_AFTER_LOAD;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d   = rem_step_s;
            quo_d   = quo_step_s;
            cnt_d   = cnt_q - 5'd1;
            busy_d  = (cnt_q != 5'd1);
            valid_d = (cnt_q == 5'd1);
        end else begin
            busy_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy     = busy_q;
    assign q_valid  = valid_q;
    assign quotient = quo_q;

endmodule

// File: rtl/centroid_update.sv
// End-of-iteration k-means centroid update: new centroid = saturated floor(sum/count) per lane,
// written back for every centroid, with a sticky flag telling whether any centroid moved.
module centroid_update
    import km_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   changed,
    output logic                   accum_rd_en,
    output logic [IDX_WIDTH-1:0]   accum_rd_addr,
    input  logic [ACCUM_WIDTH-1:0] accum_sum_in,
    input  logic [COUNT_WIDTH-1:0] accum_cnt_in,
    input  logic [DATA_WIDTH-1:0]  old_centroid_in,
    output logic                   cent_wr_en,
    output logic [IDX_WIDTH-1:0]   cent_wr_addr,
    output logic [DATA_WIDTH-1:0]  cent_wr_data
);

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(CENTROID_NUM - 1);

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d, rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  old_q, old_d, wr_data_q, wr_data_d, new_data_s;
    logic                   cnt_zero_q, cnt_zero_d, changed_q, changed_d;
    logic                   busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d;

    logic                        div_load_s, div_finished_s;
    logic [NUM_CORDS-1:0]        div_busy_s, div_valid_s;
    logic [ACCUM_CORD_WIDTH-1:0] div_quo_s [NUM_CORDS];

    assign div_load_s     = (state_q == LOAD);
    assign div_finished_s = (&div_valid_s) & ~(|div_busy_s);

    for (genvar g = 0; g < NUM_CORDS; g++) begin : g_lane
        serial_divider u_div (
            .clk      (clk),
            .rst      (rst),
            .load     (div_load_s),
            .dividend (get_sum_lane(accum_sum_in, g)),
            .divisor  (accum_cnt_in),
            .busy     (div_busy_s[g]),
            .q_valid  (div_valid_s[g]),
            .quotient (div_quo_s[g])
        );
    end

    // Repack the lane quotients into a centroid word.
    always_comb begin
        new_data_s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_CORDS; k++) begin
            new_data_s = set_cord_lane(new_data_s, k, saturate(div_quo_s[k]));
        end
    end

    // FSM next state and next values of all registered outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        old_d      = old_q;
        cnt_zero_d = cnt_zero_q;
        changed_d  = changed_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RD;
                    idx_d     = {IDX_WIDTH{1'b0}};
                    changed_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RD:   state_d = LOAD;
            LOAD: begin
                old_d      = old_centroid_in;
                cnt_zero_d = (accum_cnt_in == {COUNT_WIDTH{1'b0}});
                state_d    = DIV;
            end
            DIV: begin
                if (div_finished_s) begin
                    state_d   = WR;
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = cnt_zero_q ? old_q : new_data_s;
                    changed_d = changed_q | (wr_data_d != old_q);
                end else begin
                    state_d = DIV;
                end
            end
            WR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = RD;
                    idx_d   = idx_q + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rd_en_d   = (state_d == RD);
        rd_addr_d = (state_d == RD) ? idx_d : rd_addr_q;
        busy_d    = (state_d == RD) || (state_d == LOAD) || (state_d == DIV) || (state_d == WR);
        done_d    = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            old_q      <= '0;
            cnt_zero_q <= 1'b0;
            changed_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            old_q      <= old_d;
            cnt_zero_q <= cnt_zero_d;
            changed_q  <= changed_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign changed       = changed_q;
    assign accum_rd_en   = rd_en_q;
    assign accum_rd_addr = rd_addr_q;
    assign cent_wr_en    = wr_en_q;
    assign cent_wr_addr  = wr_addr_q;
    assign cent_wr_data  = wr_data_q;

endmodule

// File: tb/tb_centroid_update.sv
// Self-checking bench for centroid_update: RAM models plus a scoreboard of expected writes.
module tb_centroid_update;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy, done, changed, accum_rd_en, cent_wr_en;
    logic [2:0]   accum_rd_addr, cent_wr_addr;
    logic [153:0] sum_rd = '0;
    logic [9:0]   cnt_rd = '0;
    logic [90:0]  old_rd = '0;
    logic [90:0]  cent_wr_data;

    logic [153:0] sum_mem  [8];
    logic [9:0]   cnt_mem  [8];
    logic [90:0]  cent_mem [8];

    typedef struct packed {
        logic [2:0]  addr;
        logic [90:0] data;
    } wr_t;
    wr_t exp_q[$];

    int total = 0;
    int bad   = 0;

    centroid_update dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .changed         (changed),
        .accum_rd_en     (accum_rd_en),
        .accum_rd_addr   (accum_rd_addr),
        .accum_sum_in    (sum_rd),
        .accum_cnt_in    (cnt_rd),
        .old_centroid_in (old_rd),
        .cent_wr_en      (cent_wr_en),
        .cent_wr_addr    (cent_wr_addr),
        .cent_wr_data    (cent_wr_data)
    );

    always #5 clk = ~clk;

    // Accumulator and centroid RAM read ports, one-cycle latency.
    always @(posedge clk) begin
        if (accum_rd_en) begin
            sum_rd <= sum_mem[accum_rd_addr];
            cnt_rd <= cnt_mem[accum_rd_addr];
            old_rd <= cent_mem[accum_rd_addr];
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [90:0] model_cent(input logic [153:0] s, input logic [9:0] c,
                                               input logic [90:0] old);
        logic [90:0] r;
        longint q;
        if (c == 10'd0) return old;
        r = '0;
        for (int k = 0; k < 7; k++) begin
            q = longint'(s[k*22 +: 22]) / longint'(c);
            if (q > 64'sd8191) q = 64'sd8191;
            r[k*13 +: 13] = q[12:0];
        end
        return r;
    endfunction

    function automatic logic [153:0] sum_all(input logic [21:0] v);
        logic [153:0] r;
        for (int k = 0; k < 7; k++) r[k*22 +: 22] = v;
        return r;
    endfunction

    function automatic logic [90:0] cent_all(input logic [12:0] v);
        logic [90:0] r;
        for (int k = 0; k < 7; k++) r[k*13 +: 13] = v;
        return r;
    endfunction

    // Runs one update; rst_at > 0 aborts with a reset in that cycle (cycle 1 = after start edge).
    task automatic run_job(input int restart_at, input int rst_at);
        int   cyc, done_cyc, wr_cnt;
        wr_t  e;
        logic exp_changed;
        bit   aborted;
        exp_q.delete();
        exp_changed = 1'b0;
        for (int i = 0; i < 8; i++) begin
            e.addr = 3'(i);
            e.data = model_cent(sum_mem[i], cnt_mem[i], cent_mem[i]);
            exp_changed = exp_changed | (e.data != cent_mem[i]);
            exp_q.push_back(e);
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; done_cyc = 0; wr_cnt = 0; aborted = 1'b0;
        check("busy_after_start", busy, 1'b1);
        while (cyc < 400 && done_cyc == 0 && !aborted) begin
            if (cent_wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", cent_wr_en, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", cent_wr_addr, e.addr);
                    check("wr_data", cent_wr_data, e.data);
                    cent_mem[cent_wr_addr] = cent_wr_data;
                end
            end
            if (done) done_cyc = cyc;
            start = (cyc == restart_at);
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check("busy_async_rst", busy, 1'b0);
                check("wr_en_async_rst", cent_wr_en, 1'b0);
                aborted = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk); rst = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (cent_wr_en || busy) wr_cnt++;
            end
            check("writes_before_rst", wr_cnt, 2);
            check("pending_after_rst", exp_q.size(), 6);
            check("changed_after_rst", changed, 1'b0);
        end else begin
            check("done_cycle", done_cyc, 201);
            check("wr_count", wr_cnt, 8);
            check("changed", changed, exp_changed);
            check("done_pulse_end", done, 1'b0);
            check("busy_end", busy, 1'b0);
            check("changed_held", changed, exp_changed);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            sum_mem[i] = '0; cnt_mem[i] = '0; cent_mem[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_changed", changed, 1'b0);
        check("rst_rd_en", accum_rd_en, 1'b0);
        check("rst_wr_en", cent_wr_en, 1'b0);
        check("rst_addrs", {accum_rd_addr, cent_wr_addr}, 6'd0);
        check("rst_wr_data", cent_wr_data, 91'd0);
        rst = 1'b0;
        @(negedge clk);

        // Uniform 1000/10 into zero centroids, with a start re-pulse while busy.
        for (int i = 0; i < 8; i++) begin
            sum_mem[i] = sum_all(22'd1000); cnt_mem[i] = 10'd10; cent_mem[i] = '0;
        end
        run_job(50, 0);

        // Truncation, saturation, mixed lanes, zero count, random counts.
        sum_mem[0] = sum_all(22'd1009);    cnt_mem[0] = 10'd10; cent_mem[0] = '0;
        sum_mem[1] = sum_all(22'd4194303); cnt_mem[1] = 10'd1;  cent_mem[1] = '0;
        for (int k = 0; k < 7; k++) sum_mem[2][k*22 +: 22] = 22'((k + 1) * 7 * 4);
        cnt_mem[2] = 10'd4; cent_mem[2] = '0;
        sum_mem[3] = sum_all(22'd777); cnt_mem[3] = 10'd0; cent_mem[3] = cent_all(13'd555);
        sum_mem[4] = sum_all(22'd4194303); cnt_mem[4] = 10'd1023; cent_mem[4] = '0;
        for (int i = 5; i < 8; i++) begin
            for (int k = 0; k < 7; k++) sum_mem[i][k*22 +: 22] = 22'($urandom_range(0, 4194303));
            cnt_mem[i]  = 10'($urandom_range(1, 1023));
            cent_mem[i] = {27'($urandom), 32'($urandom), 32'($urandom)};
        end
        run_job(0, 0);

        // Centroids already at their means (and one empty cluster): nothing moves.
        for (int i = 0; i < 8; i++) begin
            cnt_mem[i] = 10'(i + 2);
            for (int k = 0; k < 7; k++) begin
                sum_mem[i][k*22 +: 22]  = 22'((10 * i + k + 1) * (i + 2) + (i + 1));
                cent_mem[i][k*13 +: 13] = 13'(10 * i + k + 1);
            end
        end
        sum_mem[3] = sum_all(22'd12345); cnt_mem[3] = 10'd0; cent_mem[3] = cent_all(13'd555);
        run_job(0, 0);

        // Reset in the middle of centroid 2, then a fresh run completes.
        for (int i = 0; i < 8; i++) begin
            sum_mem[i] = sum_all(22'(3000 + i)); cnt_mem[i] = 10'd30; cent_mem[i] = '0;
        end
        run_job(0, 60);
        check("mem2_untouched", cent_mem[2], 91'd0);
        run_job(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
